// File: rtl/ov7670_capture_ctrl.sv
// ov7670_capture_ctrl
//   Frame-capture sequencer for the OV7670 pixel path. Arms on a capture
//   request, aligns to the next frame's vsync, pairs camera bytes into RGB565
//   words and drives the frame-buffer BRAM write port. Reports frame completion
//   and line/frame geometry errors.
//
// Ports
//   pclk        in   camera pixel clock, all logic on posedge
//   reset       in   asynchronous active-high reset
//   din         in   camera data byte
//   vsync       in   high during vertical blank
//   href        in   high while line bytes are valid
//   start       in   capture request, sampled only in idle
//   continuous  in   1: re-arm after each frame, 0: single shot
//   abort       in   synchronous abort to idle, no frame_done
//   wr_en       out  frame-buffer write strobe, one pclk per pixel
//   wr_addr     out  write address = line*H_PIXELS + pixel
//   wr_data     out  {first byte, second byte}
//   busy        out  high in every state except idle
//   frame_done  out  one-pclk pulse at end of each captured frame
//   line_err    out  sticky: a line was not 2*H_PIXELS bytes
//   frame_err   out  sticky: a frame was not V_LINES lines
//   frame_cnt   out  captured-frame counter, wraps
module ov7670_capture_ctrl #(
  parameter int unsigned H_PIXELS = 640,
  parameter int unsigned V_LINES  = 480,
  parameter int unsigned ADDR_W   = 19
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic [7:0]        din,
  input  logic              vsync,
  input  logic              href,
  input  logic              start,
  input  logic              continuous,
  input  logic              abort,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              line_err,
  output logic              frame_err,
  output logic [7:0]        frame_cnt
);

  // Pixel counter saturates one past H_PIXELS so long lines stay detectable.
  localparam int unsigned PixW  = $clog2(H_PIXELS + 2);
  localparam int unsigned LineW = $clog2(V_LINES + 1);

  localparam logic [PixW-1:0]   HPix    = PixW'(H_PIXELS);
  localparam logic [PixW-1:0]   PixSat  = PixW'(H_PIXELS + 1);
  localparam logic [LineW-1:0]  LineMax = LineW'(V_LINES);
  localparam logic [ADDR_W-1:0] HAddr   = ADDR_W'(H_PIXELS);

  typedef enum logic [2:0] {
    StIdle,
    StSyncHi,
    StSyncLo,
    StLine,
    StPixel
  } state_e;

  state_e            state_q, state_d;
  logic              phase_q, phase_d;
  logic [7:0]        hi_q, hi_d;
  logic [PixW-1:0]   pix_q, pix_d;
  logic [LineW-1:0]  line_q, line_d;
  logic              extra_q, extra_d;  // a line arrived after V_LINES lines
  logic [ADDR_W-1:0] base_q, base_d;

  logic              wr_en_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [15:0]       wr_data_d;
  logic              busy_d;
  logic              frame_done_d;
  logic              line_err_d;
  logic              frame_err_d;
  logic [7:0]        frame_cnt_d;

  logic              take_byte;
  logic              line_close;
  logic              frame_close;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    hi_d         = hi_q;
    pix_d        = pix_q;
    line_d       = line_q;
    extra_d      = extra_q;
    base_d       = base_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr;
    wr_data_d    = wr_data;
    frame_done_d = 1'b0;
    line_err_d   = line_err;
    frame_err_d  = frame_err;
    frame_cnt_d  = frame_cnt;
    take_byte    = 1'b0;
    line_close   = 1'b0;
    frame_close  = 1'b0;

    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d     = StSyncHi;
            line_err_d  = 1'b0;
            frame_err_d = 1'b0;
            phase_d     = 1'b0;
            pix_d       = '0;
            line_d      = '0;
            extra_d     = 1'b0;
            base_d      = '0;
          end
        end
        StSyncHi: begin
          // Wait for blank so capture never begins mid-frame.
          if (vsync) state_d = StSyncLo;
        end
        StSyncLo: begin
          if (!vsync) begin
            state_d = StLine;
            phase_d = 1'b0;
            pix_d   = '0;
            line_d  = '0;
            extra_d = 1'b0;
            base_d  = '0;
          end
        end
        StLine: begin
          if (vsync) begin
            frame_close = 1'b1;
          end else if (href) begin
            state_d   = StPixel;
            take_byte = 1'b1;
          end
        end
        StPixel: begin
          if (vsync) begin
            line_close  = 1'b1;
            frame_close = 1'b1;
          end else if (href) begin
            take_byte = 1'b1;
          end else begin
            line_close = 1'b1;
            state_d    = StLine;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (take_byte) begin
      phase_d = ~phase_q;
      if (!phase_q) begin
        hi_d = din;
      end else begin
        // Out-of-range pixels are counted but never written.
        if (pix_q < HPix && line_q < LineMax) begin
          wr_en_d   = 1'b1;
          wr_data_d = {hi_q, din};
          wr_addr_d = base_q + ADDR_W'(pix_q);
        end
        if (pix_q != PixSat) pix_d = pix_q + 1'b1;
      end
    end

    // A trailing odd byte leaves phase set, which also flags the line.
    if (line_close) begin
      if (pix_q != HPix || phase_q) line_err_d = 1'b1;
      pix_d   = '0;
      phase_d = 1'b0;
      if (line_q != LineMax) begin
        line_d = line_q + 1'b1;
        base_d = base_q + HAddr;
      end else begin
        extra_d = 1'b1;
      end
    end

    // Uses the line count after any cut line has been closed.
    if (frame_close) begin
      frame_done_d = 1'b1;
      frame_cnt_d  = frame_cnt + 8'd1;
      if (line_d != LineMax || extra_d) frame_err_d = 1'b1;
      pix_d   = '0;
      phase_d = 1'b0;
      state_d = continuous ? StSyncLo : StIdle;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      phase_q    <= 1'b0;
      hi_q       <= '0;
      pix_q      <= '0;
      line_q     <= '0;
      extra_q    <= 1'b0;
      base_q     <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      line_err   <= 1'b0;
      frame_err  <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      hi_q       <= hi_d;
      pix_q      <= pix_d;
      line_q     <= line_d;
      extra_q    <= extra_d;
      base_q     <= base_d;
      wr_en      <= wr_en_d;
      wr_addr    <= wr_addr_d;
      wr_data    <= wr_data_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
      line_err   <= line_err_d;
      frame_err  <= frame_err_d;
      frame_cnt  <= frame_cnt_d;
    end
  end

endmodule
